// File: rtl/stack_port_arbiter.sv
// rtl/stack_port_arbiter.sv - round-robin arbiter sharing one LIFO stack among NREQ requesters
// Each op runs ARB -> CMD -> SETTLE so stack flags are re-sampled only after they have settled.
module stack_port_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_push,
  input  logic [NREQ-1:0]       req_pop,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH-1:0]      stk_din,
  input  logic [WIDTH-1:0]      stk_dout,
  input  logic                  stk_empty,
  input  logic                  stk_full
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {ST_ARB, ST_CMD, ST_SETTLE} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             op_pop_q, op_pop_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic             stk_push_q, stk_push_d;
  logic             stk_pop_q, stk_pop_d;
  logic [WIDTH-1:0] stk_din_q, stk_din_d;

  logic             found;
  logic [IDW-1:0]   sel;
  logic             sel_pop;
  logic [IDW:0]     scan;
  logic [WIDTH-1:0] sel_data;

  // Scan from rr_ptr; a requester holding push is never considered for pop in the same ARB.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    sel_pop = 1'b0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
      if (!found) begin
        if (req_push[scan[IDW-1:0]] && !stk_full) begin
          found   = 1'b1;
          sel     = scan[IDW-1:0];
          sel_pop = 1'b0;
        end else if (!req_push[scan[IDW-1:0]] && req_pop[scan[IDW-1:0]] && !stk_empty) begin
          found   = 1'b1;
          sel     = scan[IDW-1:0];
          sel_pop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IDW'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_pop_d    = op_pop_q;
    stk_din_d   = stk_din_q;
    grant_d     = '0;
    rsp_valid_d = '0;
    stk_push_d  = 1'b0;
    stk_pop_d   = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (found) begin
          state_d    = ST_CMD;
          id_d       = sel;
          op_pop_d   = sel_pop;
          stk_din_d  = sel_data;
          grant_d    = NREQ'(1) << sel;
          stk_push_d = !sel_pop;
          stk_pop_d  = sel_pop;
        end
      end
      ST_CMD: begin
        rr_ptr_d = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
        if (op_pop_q) rsp_valid_d = NREQ'(1) << id_q;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_ARB;
      default:   state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_pop_q    <= 1'b0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
      stk_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      op_pop_q    <= op_pop_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      stk_push_q  <= stk_push_d;
      stk_pop_q   <= stk_pop_d;
      stk_din_q   <= stk_din_d;
    end
  end

  assign grant     = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign stk_push  = stk_push_q;
  assign stk_pop   = stk_pop_q;
  assign stk_din   = stk_din_q;
  // Stack dout is already registered; it is valid in SETTLE, exactly when rsp_valid is up.
  assign rsp_data  = (|rsp_valid_q) ? stk_dout : '0;

endmodule
